cl_compute_engine_arbiter: RTL

- Shares one compute engine (separator -> compute unit -> result combiner) between N_REQ independent request streams.
- Arbitrates whole compute requests round-robin and forwards each granted request to the engine.
- Records the requester index of every granted request in an in-order tag FIFO and routes each engine result back to the requester that issued it.
- Sits between the per-channel request/result FIFOs and the compute engine wrapper. The engine is strictly in-order.

---
 rtl/cl_compute_engine_arbiter.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cl_compute_engine_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cl_compute_engine_arbiter                                  |
// | Description : Shares one in-order compute engine between N_REQ request  |
// |               streams. Whole requests are granted round-robin and passed |
// |               through combinationally to the engine. The requester index |
// |               of every grant is pushed into an in-order tag FIFO, and    |
// |               the FIFO head steers each engine result back to the        |
// |               requester that issued it.                                  |
// | Ports       : clock_i, reset_i        clock, synchronous active-high rst |
// |               req_valid_i/ready_o/data_i   per-requester request beats   |
// |               eng_req_valid_o/ready_i/data_o  request beats to engine    |
// |               eng_res_valid_i/ready_o/data_i  result beats from engine   |
// |               res_valid_o/ready_i, res_data_o  per-requester results     |
// |               inflight_o  granted requests whose results are pending     |
// |               busy_o      request FSM active or results outstanding      |
// | Option      : `define CL_COMPUTE_ARB_STATS_EN adds grant_cnt_o (per-     |
// |               requester completed requests) and stall_cnt_o (cycles a    |
// |               grant is blocked by a full tag FIFO), both saturating.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cl_compute_engine_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 512,
    parameter int REQ_BEATS = 1,
    parameter int RES_BEATS = 1,
    parameter int TAG_DEPTH = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*DATA_W-1:0]        req_data_i,
    output logic                           eng_req_valid_o,
    input  logic                           eng_req_ready_i,
    output logic [DATA_W-1:0]              eng_req_data_o,
    input  logic                           eng_res_valid_i,
    output logic                           eng_res_ready_o,
    input  logic [DATA_W-1:0]              eng_res_data_i,
    output logic [N_REQ-1:0]               res_valid_o,
    input  logic [N_REQ-1:0]               res_ready_i,
    output logic [DATA_W-1:0]              res_data_o,
    output logic [$clog2(TAG_DEPTH+1)-1:0] inflight_o,
    output logic                           busy_o
`ifdef CL_COMPUTE_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]            grant_cnt_o,
    output logic [31:0]                    stall_cnt_o
`endif
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(TAG_DEPTH + 1);
    localparam int c_PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_RQB_W = (REQ_BEATS > 1) ? $clog2(REQ_BEATS) : 1;
    localparam int c_RSB_W = (RES_BEATS > 1) ? $clog2(RES_BEATS) : 1;

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(TAG_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(TAG_DEPTH - 1);
    localparam logic [c_RQB_W-1:0] c_REQ_LAST = c_RQB_W'(REQ_BEATS - 1);
    localparam logic [c_RSB_W-1:0] c_RES_LAST = c_RSB_W'(RES_BEATS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FWD  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_sel;
    logic [c_IDX_W-1:0] r_last_grant;
    logic [c_RQB_W-1:0] r_req_cnt;
    logic [c_RSB_W-1:0] r_res_cnt;

    logic [c_IDX_W-1:0] r_tag_mem [TAG_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_grant;
    logic [c_IDX_W-1:0] w_pick;
    logic               w_hi_found;
    logic [c_IDX_W-1:0] w_hi_idx;
    logic [c_IDX_W-1:0] w_lo_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_req_xfer;
    logic               w_req_last;
    logic [c_IDX_W-1:0] w_head;
    logic               w_res_xfer;
    logic               w_pop;

    assign w_fifo_full  = (r_count == c_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_grant      = (r_state == S_IDLE) && (|req_valid_i) && !w_fifo_full;

    // Round-robin pick: the lowest valid index above last_grant wins; if there
    // is none, wrap around to the lowest valid index overall. Scanning downward
    // lets the last write in each class be the lowest index.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_lo_idx = c_IDX_W'(i);
                if (i > int'(r_last_grant)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_IDX_W'(i);
                end
            end
        end
    end

    assign w_pick = w_hi_found ? w_hi_idx : w_lo_idx;

    // Data of the currently selected requester.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (k == int'(r_sel)) begin
                w_sel_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_req_xfer = (r_state == S_FWD) && req_valid_i[r_sel] && eng_req_ready_i;
    assign w_req_last = w_req_xfer && (r_req_cnt == c_REQ_LAST);

    assign w_head     = r_tag_mem[r_rd_ptr];
    assign w_res_xfer = !w_fifo_empty && eng_res_valid_i && res_ready_i[w_head];
    assign w_pop      = w_res_xfer && (r_res_cnt == c_RES_LAST);

    // ------------------------------------------------------------------
    // Request FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_FWD;
                end
            end
            S_FWD: begin
                // Once granted, the request runs to its last beat even if the
                // requester drops valid in between.
                if (w_req_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request FSM: outputs (zero-latency pass-through while forwarding)
    always_comb begin
        req_ready_o     = '0;
        eng_req_valid_o = 1'b0;
        eng_req_data_o  = '0;
        if (r_state == S_FWD) begin
            eng_req_valid_o    = req_valid_i[r_sel];
            eng_req_data_o     = w_sel_data;
            req_ready_o[r_sel] = eng_req_ready_i;
        end
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_sel        <= '0;
            r_last_grant <= c_IDX_LAST;
            r_req_cnt    <= '0;
            r_res_cnt    <= '0;
        end else begin
            if (w_grant) begin
                r_sel        <= w_pick;
                r_last_grant <= w_pick;
            end
            if (w_req_xfer) begin
                r_req_cnt <= w_req_last ? '0 : r_req_cnt + 1'b1;
            end
            if (w_res_xfer) begin
                r_res_cnt <= w_pop ? '0 : r_res_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (w_grant) begin
            r_tag_mem[r_wr_ptr] <= w_pick;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_grant) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            // A grant and a final result beat in the same cycle cancel out.
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result routing: the FIFO head selects the destination. With no tag
    // outstanding the engine is stalled rather than its result discarded.
    // ------------------------------------------------------------------
    always_comb begin
        res_valid_o     = '0;
        res_data_o      = '0;
        eng_res_ready_o = 1'b0;
        if (!w_fifo_empty) begin
            res_valid_o[w_head] = eng_res_valid_i;
            res_data_o          = eng_res_data_i;
            eng_res_ready_o     = res_ready_i[w_head];
        end
    end

    assign inflight_o = r_count;
    assign busy_o     = (r_state != S_IDLE) || !w_fifo_empty;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef CL_COMPUTE_ARB_STATS_EN
    logic [31:0] r_stall_cnt;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_grant_cnt
            logic [31:0] r_cnt;
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    r_cnt <= '0;
                end else if (w_req_last && (int'(r_sel) == g) && (r_cnt != 32'hFFFF_FFFF)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign grant_cnt_o[g*32 +: 32] = r_cnt;
        end
    endgenerate

    // Only an idle FSM with pending requests can be blocked by a full FIFO.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && (|req_valid_i) && w_fifo_full &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
